// File: rtl/ring8_decoder_pkg.sv
// Shared types and widths for the ring8_decoder block (FSM states, ring/index widths).
// Optional error counter in the top is enabled with RING8_DECODER_ERRCNT_EN.
package ring8_decoder_pkg;

    localparam int RING_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Ring positions wrap naturally in IDX_W bits.
    function automatic logic [IDX_W-1:0] next_pos(input logic [IDX_W-1:0] pos);
        return pos + IDX_W'(1);
    endfunction

endpackage

// File: rtl/ring8_decoder_onehot8_enc.sv
// Combinational one-hot 8->3 encoder with a legality flag (exactly one bit set).
module onehot8_enc
    import ring8_decoder_pkg::*;
(
    input  logic [RING_W-1:0] ring,
    output logic [IDX_W-1:0]  pos,
    output logic              legal
);

    logic [RING_W-1:0] ring_m1;

    assign ring_m1 = ring - RING_W'(1);

    // Power-of-two test: nonzero and clearing the lowest set bit leaves nothing.
    assign legal = (ring != '0) && ((ring & ring_m1) == '0);

    assign pos[0] = ring[1] | ring[3] | ring[5] | ring[7];
    assign pos[1] = ring[2] | ring[3] | ring[6] | ring[7];
    assign pos[2] = ring[4] | ring[5] | ring[6] | ring[7];

endmodule

// File: rtl/ring8_decoder.sv
// One-hot ring position decoder with sequence lock tracking, WRAP and ERR pulses.
// Define RING8_DECODER_ERRCNT_EN to add the saturating ERRCNT output.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_HUNT    | no reference position; waiting for a legal sample
//   ST_ACQUIRE | counting consecutive correct advances toward LOCK_COUNT
//   ST_LOCKED  | sequence tracked; any deviation flags ERR and drops to HUNT
module ring8_decoder
    import ring8_decoder_pkg::*;
#(
    parameter int LOCK_COUNT = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [RING_W-1:0] I,
    input  logic              VALID,
    output logic [IDX_W-1:0]  IDX,
    output logic              IDX_VALID,
    output logic              LOCKED,
    output logic              ERR,
`ifdef RING8_DECODER_ERRCNT_EN
    output logic              WRAP,
    output logic [7:0]        ERRCNT
`else
    output logic              WRAP
`endif
);

    localparam logic [2:0] LOCK_CNT = 3'(LOCK_COUNT);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] prev, prev_nxt;
    logic [2:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             idx_valid_nxt;
    logic             locked_nxt;
    logic             err_nxt;
    logic             wrap_nxt;

    logic [IDX_W-1:0] pos;
    logic             legal;
    logic             in_seq;

    onehot8_enc u_enc (
        .ring  (I),
        .pos   (pos),
        .legal (legal)
    );

    assign in_seq = legal && (pos == next_pos(prev));

    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        cnt_nxt       = cnt;
        idx_nxt       = IDX;
        idx_valid_nxt = 1'b0;
        err_nxt       = 1'b0;
        wrap_nxt      = 1'b0;

        if (VALID) begin
            if (legal) begin
                idx_nxt       = pos;
                idx_valid_nxt = 1'b1;
            end

            unique case (state)
                ST_HUNT: begin
                    if (legal) begin
                        state_nxt = ST_ACQUIRE;
                        prev_nxt  = pos;
                        cnt_nxt   = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (!legal) begin
                        state_nxt = ST_HUNT;
                        cnt_nxt   = '0;
                    end else if (in_seq) begin
                        prev_nxt = pos;
                        cnt_nxt  = cnt + 3'd1;
                        if (cnt + 3'd1 == LOCK_CNT) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else begin
                        prev_nxt = pos;
                        cnt_nxt  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (in_seq) begin
                        prev_nxt = pos;
                        wrap_nxt = (prev == 3'd7);
                    end else begin
                        // Legal-but-wrong samples still refresh prev; HUNT reloads it anyway.
                        if (legal) begin
                            prev_nxt = pos;
                        end
                        err_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_HUNT;
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                    cnt_nxt   = '0;
                end
            endcase
        end

        locked_nxt = (state_nxt == ST_LOCKED);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_HUNT;
            prev      <= '0;
            cnt       <= '0;
            IDX       <= '0;
            IDX_VALID <= 1'b0;
            LOCKED    <= 1'b0;
            ERR       <= 1'b0;
            WRAP      <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            cnt       <= cnt_nxt;
            IDX       <= idx_nxt;
            IDX_VALID <= idx_valid_nxt;
            LOCKED    <= locked_nxt;
            ERR       <= err_nxt;
            WRAP      <= wrap_nxt;
        end
    end

`ifdef RING8_DECODER_ERRCNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ERRCNT <= '0;
        end else if (err_nxt && (ERRCNT != 8'hFF)) begin
            ERRCNT <= ERRCNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring8_decoder.sv
// Scoreboard bench for ring8_decoder: a behavioural reference pushes expected outputs per sample.
`timescale 1ns/1ps
module tb_ring8_decoder;

    localparam int LOCK_COUNT = 3;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] I;
    logic       VALID;
    logic [2:0] IDX;
    logic       IDX_VALID, LOCKED, ERR, WRAP;
`ifdef RING8_DECODER_ERRCNT_EN
    logic [7:0] ERRCNT;
`endif

    ring8_decoder #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .I         (I),
        .VALID     (VALID),
        .IDX       (IDX),
        .IDX_VALID (IDX_VALID),
        .LOCKED    (LOCKED),
        .ERR       (ERR),
`ifdef RING8_DECODER_ERRCNT_EN
        .WRAP      (WRAP),
        .ERRCNT    (ERRCNT)
`else
        .WRAP      (WRAP)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] idx;
        logic       iv;
        logic       lk;
        logic       er;
        logic       wr;
        logic [7:0] ec;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state: 0 hunt, 1 acquire, 2 locked
    int         m_state;
    int         m_prev;
    int         m_cnt;
    logic [2:0] m_idx;
    logic [7:0] m_ec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_prev  = 0;
        m_cnt   = 0;
        m_idx   = 3'd0;
        m_ec    = 8'd0;
    endtask

    // Drive one sample, predict, wait one edge, compare against the oldest prediction.
    task automatic apply(input logic [7:0] val, input logic v);
        exp_t e, o;
        int   p;
        bit   lg;
        I     = val;
        VALID = v;
        p  = 0;
        lg = ($countones(val) == 1);
        for (int k = 0; k < 8; k++) if (val[k]) p = k;
        e.iv = 1'b0;
        e.er = 1'b0;
        e.wr = 1'b0;
        if (v) begin
            if (lg) begin
                m_idx = 3'(p);
                e.iv  = 1'b1;
            end
            case (m_state)
                0: if (lg) begin m_state = 1; m_prev = p; m_cnt = 0; end
                1: begin
                    if (!lg) m_state = 0;
                    else if (p == (m_prev + 1) % 8) begin
                        m_cnt++;
                        m_prev = p;
                        if (m_cnt == LOCK_COUNT) m_state = 2;
                    end else begin
                        m_prev = p;
                        m_cnt  = 0;
                    end
                end
                default: begin
                    if (lg && p == (m_prev + 1) % 8) begin
                        e.wr   = (m_prev == 7) && (p == 0);
                        m_prev = p;
                    end else begin
                        e.er    = 1'b1;
                        m_state = 0;
                        if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
                    end
                end
            endcase
        end
        e.idx = m_idx;
        e.lk  = (m_state == 2);
        e.ec  = m_ec;
        sb.push_back(e);

        @(posedge CLK);
        #1;
        o = sb.pop_front();
        check("idx",       IDX,       o.idx);
        check("idx_valid", IDX_VALID, o.iv);
        check("locked",    LOCKED,    o.lk);
        check("err",       ERR,       o.er);
        check("wrap",      WRAP,      o.wr);
`ifdef RING8_DECODER_ERRCNT_EN
        check("errcnt",    ERRCNT,    o.ec);
`endif
    endtask

    task automatic lock_from(input int start);
        for (int k = 0; k <= LOCK_COUNT; k++) apply(8'h01 << ((start + k) % 8), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        I     = 8'h00;
        VALID = 1'b0;
        model_reset();
        #12;
        check("rst_idx",    IDX,       0);
        check("rst_iv",     IDX_VALID, 0);
        check("rst_locked", LOCKED,    0);
        check("rst_err",    ERR,       0);
        check("rst_wrap",   WRAP,      0);
`ifdef RING8_DECODER_ERRCNT_EN
        check("rst_errcnt", ERRCNT,    0);
`endif
        RESET = 1'b0;

        // acquisition from reset: first edge after release samples
        apply(8'h01, 1'b1);
        check("acq_idx0", IDX, 0);
        apply(8'h02, 1'b1);
        apply(8'h04, 1'b1);
        check("acq_not_locked", LOCKED, 0);
        apply(8'h08, 1'b1);
        check("acq_idx3", IDX, 3);
        check("acq_locked", LOCKED, 1);

        // wrap 7 -> 0
        apply(8'h10, 1'b1);
        apply(8'h20, 1'b1);
        apply(8'h40, 1'b1);
        apply(8'h80, 1'b1);
        check("wrap_idx7", IDX, 7);
        check("wrap_early", WRAP, 0);
        apply(8'h01, 1'b1);
        check("wrap_idx0", IDX, 0);
        check("wrap_pulse", WRAP, 1);
        check("wrap_noerr", ERR, 0);
        apply(8'h02, 1'b1);
        check("wrap_single", WRAP, 0);

        // skip while locked at 2
        apply(8'h04, 1'b1);
        apply(8'h10, 1'b1);
        check("skip_err", ERR, 1);
        check("skip_unlock", LOCKED, 0);
        check("skip_idx", IDX, 4);
        check("skip_iv", IDX_VALID, 1);

        // illegal samples while locked (ends at 3)
        lock_from(0);
        apply(8'h03, 1'b1);
        check("multi_err", ERR, 1);
        check("multi_idx", IDX, 3);
        check("multi_iv", IDX_VALID, 0);
        apply(8'h00, 1'b1);
        check("zero_noerr", ERR, 0);
        check("zero_iv", IDX_VALID, 0);
        check("zero_idx", IDX, 3);

        // idle while locked (ends at 0)
        lock_from(5);
        for (int k = 0; k < 10; k++) begin
            apply(8'($urandom), 1'b0);
            check("idle_locked", LOCKED, 1);
        end
        apply(8'h02, 1'b1);
        check("idle_resume_locked", LOCKED, 1);
        check("idle_resume_noerr", ERR, 0);

        // asynchronous reset mid-stream
        RESET = 1'b1;
        #1;
        check("arst_idx",    IDX,       0);
        check("arst_iv",     IDX_VALID, 0);
        check("arst_locked", LOCKED,    0);
        check("arst_err",    ERR,       0);
        check("arst_wrap",   WRAP,      0);
        model_reset();
        #1;
        RESET = 1'b0;
        for (int k = 0; k < LOCK_COUNT; k++) apply(8'h01 << ((3 + k) % 8), 1'b1);
        check("reacq_not_yet", LOCKED, 0);
        apply(8'h01 << ((3 + LOCK_COUNT) % 8), 1'b1);
        check("reacq_locked", LOCKED, 1);

        // randomised mix against the reference
        for (int k = 0; k < 300; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5)      apply(8'h01 << ((m_prev + 1) % 8), 1'b1);
            else if (kind < 7) apply(8'h01 << $urandom_range(0, 7), 1'b1);
            else if (kind < 9) apply(8'($urandom), 1'b1);
            else               apply(8'($urandom), 1'b0);
        end

        // repeated lock/error cycles to saturate the error counter
        for (int k = 0; k < 300; k++) begin
            if (m_state != 0) apply(8'h00, 1'b1);
            lock_from(k % 8);
            apply(8'h00, 1'b1);
        end
`ifdef RING8_DECODER_ERRCNT_EN
        check("errcnt_sat", ERRCNT, 255);
        RESET = 1'b1;
        #1;
        check("errcnt_clr", ERRCNT, 0);
        model_reset();
        #1;
        RESET = 1'b0;
        apply(8'h01, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ring8_decoder.md
RING8_DECODER -- requirements
Module: ring8_decoder

Interface
REQ-001 SHALL have parameter: LOCK_COUNT, 3, consecutive correct advances (1..7) required to enter LOCKED.
REQ-002 SHALL have port: CLK  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: I  input  8  one-hot ring value; bit n set = position n.
REQ-005 SHALL have port: VALID  input  1  I is sampled only when high.
REQ-006 SHALL have port: IDX  output  3  binary position of last valid one-hot sample.
REQ-007 SHALL have port: IDX_VALID  output  1  one-cycle pulse, IDX updated this cycle.
REQ-008 SHALL have port: LOCKED  output  1  level, ring sequence tracked.
REQ-009 SHALL have port: ERR  output  1  one-cycle pulse, sequence violation while LOCKED.
REQ-010 SHALL have port: WRAP  output  1  one-cycle pulse, locked advance 7->0.

Function
REQ-011 One-hot check SHALL be exactly one bit set; 0x00 or multi-bit = illegal.
REQ-012 All outputs SHALL be registered; response appears 1 cycle after the VALID sample edge.
REQ-013 Legal sample SHALL load IDX with encoded position and pulse IDX_VALID; illegal sample SHALL hold IDX, no IDX_VALID.
REQ-014 VALID low SHALL hold all state; pulses deassert.
REQ-015 FSM SHALL have states HUNT, ACQUIRE, LOCKED; reset state HUNT.
REQ-016 HUNT: legal sample -> ACQUIRE, prev=position, cnt=0; illegal -> stay HUNT.
REQ-017 ACQUIRE: legal and position==prev+1 mod 8 -> cnt+1, prev=position; when cnt reaches LOCK_COUNT -> LOCKED.
REQ-018 ACQUIRE: legal but wrong position -> stay ACQUIRE, prev=position, cnt=0; illegal -> HUNT.
REQ-019 LOCKED: legal and prev+1 mod 8 -> stay, prev=position; WRAP pulse when prev==7 and position==0.
REQ-020 LOCKED: any other sample (illegal, repeat, skip, backward) -> ERR pulse, LOCKED deasserts same cycle, -> HUNT.
REQ-021 ERR and WRAP SHALL be mutually exclusive; ERR SHALL never pulse outside LOCKED.
REQ-022 Position arithmetic SHALL be 3-bit modulo 8.

Reset
REQ-023 RESET high SHALL force, asynchronously: state HUNT, IDX=0, IDX_VALID=0, LOCKED=0, ERR=0, WRAP=0, cnt=0, prev=0, ERRCNT=0.
REQ-024 Reset mid-lock SHALL require full re-acquisition (LOCK_COUNT+1 legal samples) after release.
REQ-025 First sample SHALL be taken on the first CLK edge with RESET low.

Configuration
REQ-026 Macro RING8_DECODER_ERRCNT_EN defined: SHALL add output ERRCNT  output  8  saturating count of ERR pulses, sticks at 255, cleared only by RESET.
REQ-027 Macro absent: ERRCNT port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold FSM state enum (HUNT/ACQUIRE/LOCKED), RING_W=8, IDX_W=3.
REQ-029 Sub-module onehot8_enc SHALL provide combinational 8->3 encode plus legal flag; used once.

Verification
REQ-030 Reset release, VALID with 0x01,0x02,0x04,0x08 consecutive -> IDX 0,1,2,3; LOCKED high 1 cycle after 0x08 sample (LOCK_COUNT=3).
REQ-031 Locked at position 6, feed 0x80 then 0x01 -> IDX 7 then 0; WRAP pulse exactly with IDX=0; ERR stays 0.
REQ-032 Locked at position 2, feed 0x10 (skip) -> ERR pulse, LOCKED 0, state HUNT, IDX=4, IDX_VALID pulse.
REQ-033 Locked, feed 0x03 then 0x00 -> ERR pulse on first, IDX unchanged, no IDX_VALID for either; second no ERR.
REQ-034 Locked, VALID low 10 cycles then next legal position -> stays LOCKED, no ERR; assert RESET mid-stream -> all outputs 0 same cycle.
REQ-035 With RING8_DECODER_ERRCNT_EN, 300 induced lock/error cycles -> ERRCNT=255; RESET -> 0.
